mips_cpu_regfile_arbiter: RTL and testbench

MIPS_CPU_REGFILE_ARBITER -- requirements
Module: mips_cpu_regfile_arbiter

---
 rtl/mips_cpu_pkg.sv | 17 +
 rtl/mips_cpu_scoreboard.sv | 43 ++++
 rtl/mips_cpu_regfile_arbiter.sv | 93 +++++++++
 tb/tb_mips_cpu_regfile_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS register-file writeback path.
`default_nettype none

package mips_cpu_pkg;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ALU  = 2'd1,
    REQ_MEM  = 2'd2
  } req_t;
endpackage

`default_nettype wire

// File: rtl/mips_cpu_scoreboard.sv
// Pending-writeback scoreboard: tracks destinations reserved at issue until written back.
`default_nettype none

module mips_cpu_scoreboard
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  reg_addr_t   set_addr,
  input  logic        clr_en,
  input  reg_addr_t   clr_addr,
  input  reg_addr_t   check_addr_a,
  input  reg_addr_t   check_addr_b,
  output logic        hazard,
  output logic [31:0] pending
);

  logic [31:0] pending_next;

  // Clear applied first so a same-edge reserve of the same register wins.
  always_comb begin
    pending_next = pending;
    if (clr_en)
      pending_next[clr_addr] = 1'b0;
    if (set_en && (set_addr != REG_ZERO))
      pending_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      pending <= '0;
    else
      pending <= pending_next;
  end

  assign hazard = reset &&
                  ((pending[check_addr_a] && (check_addr_a != REG_ZERO)) ||
                   (pending[check_addr_b] && (check_addr_b != REG_ZERO)));

endmodule

`default_nettype wire

// File: rtl/mips_cpu_regfile_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port,
// with starvation protection for the ALU and a pending-register scoreboard.
`default_nettype none

module mips_cpu_regfile_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  reg_addr_t   alu_addr,
  input  word_t       alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  reg_addr_t   mem_addr,
  input  word_t       mem_data,
  output logic        mem_ready,
  input  logic        reserve_en,
  input  reg_addr_t   reserve_addr,
  input  reg_addr_t   check_addr_a,
  input  reg_addr_t   check_addr_b,
  output logic        hazard,
  output logic        rf_write_en,
  output reg_addr_t   rf_write_addr,
  output word_t       rf_write_data,
  output logic [31:0] pending
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  req_t          grant;
  reg_addr_t     win_addr;
  word_t         win_data;

  // Loads normally win; the ALU is forced through once it has lost LIMIT times.
  always_comb begin
    grant = REQ_NONE;
    if (reset) begin
      if (alu_valid && mem_valid)
        grant = (starve_cnt == LIMIT) ? REQ_ALU : REQ_MEM;
      else if (alu_valid)
        grant = REQ_ALU;
      else if (mem_valid)
        grant = REQ_MEM;
    end
  end

  assign alu_ready = (grant == REQ_ALU);
  assign mem_ready = (grant == REQ_MEM);
  assign win_addr  = (grant == REQ_MEM) ? mem_addr : alu_addr;
  assign win_data  = (grant == REQ_MEM) ? mem_data : alu_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt    <= '0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= REG_ZERO;
      rf_write_data <= '0;
    end else begin
      if ((grant == REQ_ALU) || !alu_valid)
        starve_cnt <= '0;
      else if ((grant == REQ_MEM) && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      // r0 writes finish the handshake but never reach the register file.
      rf_write_en <= (grant != REQ_NONE) && (win_addr != REG_ZERO);
      if ((grant != REQ_NONE) && (win_addr != REG_ZERO)) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
    end
  end

  mips_cpu_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (reserve_en),
    .set_addr     (reserve_addr),
    .clr_en       (rf_write_en),
    .clr_addr     (rf_write_addr),
    .check_addr_a (check_addr_a),
    .check_addr_b (check_addr_b),
    .hazard       (hazard),
    .pending      (pending)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_regfile_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
`default_nettype none

module tb_mips_cpu_regfile_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, reserve_addr, check_addr_a, check_addr_b, rf_write_addr;
  logic [31:0] alu_data, mem_data, rf_write_data, pending;
  logic        reserve_en, hazard, rf_write_en;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] m_pend;
  int        m_starve;
  bit        m_en;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_alu_gnt, m_mem_gnt;

  always #5 clk = ~clk;

  mips_cpu_regfile_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .check_addr_a(check_addr_a), .check_addr_b(check_addr_b), .hazard(hazard),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: settle, compare DUT to model, advance model, move to next negedge.
  task automatic step();
    bit rst, exp_hz;
    #1;
    rst = !reset;
    m_alu_gnt = 0;
    m_mem_gnt = 0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        if (m_starve == LIMIT) m_alu_gnt = 1; else m_mem_gnt = 1;
      end else if (alu_valid) m_alu_gnt = 1;
      else if (mem_valid) m_mem_gnt = 1;
    end
    exp_hz = !rst && ((m_pend[check_addr_a] && check_addr_a != 0) ||
                      (m_pend[check_addr_b] && check_addr_b != 0));
    check("alu_ready", 32'(alu_ready), 32'(m_alu_gnt));
    check("mem_ready", 32'(mem_ready), 32'(m_mem_gnt));
    check("hazard", 32'(hazard), 32'(exp_hz));
    check("rf_write_en", 32'(rf_write_en), 32'(m_en));
    check("rf_write_addr", 32'(rf_write_addr), 32'(m_waddr));
    check("rf_write_data", rf_write_data, m_wdata);
    check("pending", pending, m_pend);
    if (rst) begin
      m_pend = 0; m_starve = 0; m_en = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      if (m_en) m_pend[m_waddr] = 1'b0;
      if (reserve_en && reserve_addr != 0) m_pend[reserve_addr] = 1'b1;
      if (m_alu_gnt || !alu_valid) m_starve = 0;
      else if (m_mem_gnt && m_starve < LIMIT) m_starve++;
      m_en = 0;
      if (m_alu_gnt && alu_addr != 0) begin m_en = 1; m_waddr = alu_addr; m_wdata = alu_data; end
      if (m_mem_gnt && mem_addr != 0) begin m_en = 1; m_waddr = mem_addr; m_wdata = mem_data; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; reserve_en = 0;
    alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0;
    reserve_addr = 0; check_addr_a = 0; check_addr_b = 0;
  endtask

  initial begin
    m_pend = 0; m_starve = 0; m_en = 0; m_waddr = 0; m_wdata = 0;
    idle_inputs();
    reset = 0;
    @(negedge clk);
    alu_valid = 1; mem_valid = 1;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 0);
    check("rst_mem_ready", 32'(mem_ready), 0);
    step(); step();
    check("rst_pending", pending, 0);
    check("rst_wen", 32'(rf_write_en), 0);
    idle_inputs();
    reset = 1;
    step();

    // Single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    #1 check("alu_only_ready", 32'(alu_ready), 1);
    step();
    alu_valid = 0;
    check("alu_only_wen", 32'(rf_write_en), 1);
    check("alu_only_waddr", 32'(rf_write_addr), 5);
    check("alu_only_wdata", rf_write_data, 32'h1234);
    step();
    check("alu_only_wen_drop", 32'(rf_write_en), 0);

    // Starvation: mem x4 then alu, then mem again after counter clears
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA;
    mem_valid = 1; mem_addr = 4; mem_data = 32'hB;
    for (int i = 0; i < 6; i++) begin
      #1 check("starve_alu_grant", 32'(alu_ready), 32'(i == 4));
      step();
    end
    idle_inputs();
    step();

    // Reserve r7, write r7 from the ALU
    reserve_en = 1; reserve_addr = 7;
    step();
    reserve_en = 0; check_addr_a = 7;
    #1;
    check("r7_pending", 32'(pending[7]), 1);
    check("r7_hazard", 32'(hazard), 1);
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    step();
    alu_valid = 0;
    #1;
    check("r7_pending_wcycle", 32'(pending[7]), 1);
    check("r7_hazard_wcycle", 32'(hazard), 1);
    step();
    check("r7_pending_clr", 32'(pending[7]), 0);
    check("r7_hazard_clr", 32'(hazard), 0);
    check_addr_a = 0;

    // Reserve r9 on the same edge its write commits
    reserve_en = 1; reserve_addr = 9;
    step();
    reserve_en = 0; alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    step();
    alu_valid = 0; reserve_en = 1; reserve_addr = 9;
    step();
    reserve_en = 0;
    check("r9_set_wins", 32'(pending[9]), 1);

    // Load to r0 and reserve of r0
    mem_valid = 1; mem_addr = 0; mem_data = 32'hFFFF_FFFF;
    #1 check("r0_mem_ready", 32'(mem_ready), 1);
    step();
    mem_valid = 0;
    check("r0_no_write", 32'(rf_write_en), 0);
    reserve_en = 1; reserve_addr = 0;
    step();
    reserve_en = 0;
    check("r0_not_pending", 32'(pending[0]), 0);

    // Reset right after an accepted write
    alu_valid = 1; alu_addr = 12; alu_data = 32'hC0DE;
    step();
    alu_valid = 1; mem_valid = 1; reset = 0;
    #1;
    check("rst_gate_alu", 32'(alu_ready), 0);
    check("rst_gate_mem", 32'(mem_ready), 0);
    step();
    check("rst_discard_wen", 32'(rf_write_en), 0);
    check("rst_discard_pend", pending, 0);
    idle_inputs();
    reset = 1;
    step();

    // Random traffic; requesters hold addr/data until granted
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      if (!(alu_valid && !m_alu_gnt)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_addr  = 5'($urandom_range(0, 11));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !m_mem_gnt)) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_addr  = 5'($urandom_range(0, 11));
        mem_data  = $urandom;
      end
      reserve_en   = ($urandom_range(0, 1) != 0);
      reserve_addr = 5'($urandom_range(0, 11));
      check_addr_a = 5'($urandom_range(0, 11));
      check_addr_b = 5'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
